// File: rtl/note_voice_allocator_pkg.sv
// rtl/note_voice_allocator_pkg.sv - shared widths and note request type for the voice allocator
package note_voice_allocator_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int META_W = 3;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [DUR_W-1:0]  dur_t;
    typedef logic [META_W-1:0] meta_t;

    typedef struct packed {
        note_t note;
        meta_t meta;
        dur_t  dur;
    } note_req_t;

endpackage

// File: rtl/note_voice_allocator_note_voice.sv
// rtl/note_voice_allocator_note_voice.sv - one voice slot: holds a note and counts its duration down in beats
module note_voice
    import note_voice_allocator_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      flush_i,
    input  logic      load_i,
    input  logic      tick_i,
    input  note_req_t req_i,
    output logic      active_o,
    output note_t     note_o,
    output meta_t     meta_o,
    output dur_t      remaining_o,
    output logic      expiring_o
);

    logic  active_q, active_d;
    note_t note_q, note_d;
    meta_t meta_q, meta_d;
    dur_t  rem_q, rem_d;

    assign expiring_o = active_q & tick_i & (rem_q == dur_t'(1));

    // A load wins over expiry so a slot can hand over to a new note in one edge
    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        meta_d   = meta_q;
        rem_d    = rem_q;
        if (flush_i) begin
            active_d = 1'b0;
            note_d   = '0;
            meta_d   = '0;
            rem_d    = '0;
        end else if (load_i) begin
            active_d = 1'b1;
            note_d   = req_i.note;
            meta_d   = req_i.meta;
            rem_d    = req_i.dur;
        end else if (expiring_o) begin
            active_d = 1'b0;
            note_d   = '0;
            meta_d   = '0;
            rem_d    = '0;
        end else if (active_q && tick_i) begin
            rem_d = rem_q - dur_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            note_q   <= '0;
            meta_q   <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
            meta_q   <= meta_d;
            rem_q    <= rem_d;
        end
    end

    assign active_o    = active_q;
    assign note_o      = note_q;
    assign meta_o      = meta_q;
    assign remaining_o = rem_q;

endmodule

// File: rtl/note_voice_allocator.sv
// rtl/note_voice_allocator.sv - assigns incoming notes to voice slots, stealing the shortest-remaining voice when full
module note_voice_allocator
    import note_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         play_i,
    input  logic                         beat_i,
    input  logic                         new_note_i,
    input  logic [NOTE_W-1:0]            note_i,
    input  logic [DUR_W-1:0]             duration_i,
    input  logic [META_W-1:0]            metadata_i,
    output logic [NUM_VOICES-1:0]        voice_active_o,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_notes_o,
    output logic [META_W*NUM_VOICES-1:0] voice_meta_o,
    output logic                         note_done_o,
    output logic                         dropped_o
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                  tick;
    logic                  req_ok;
    logic                  req_valid;
    note_req_t             req;
    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] expiring;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] load;
    dur_t                  remaining [NUM_VOICES];

    logic                  free_hit;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      steal_idx;
    dur_t                  steal_rem;
    logic [IDX_W-1:0]      sel_idx;

    logic note_done_q, note_done_d;
    logic dropped_q, dropped_d;

    assign tick      = play_i & beat_i;
    assign req_ok    = (note_i != '0) && (duration_i != '0);
    assign req_valid = new_note_i & ~flush_i & req_ok;
    assign req       = '{note: note_i, meta: metadata_i, dur: duration_i};
    assign free      = ~active | expiring;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        note_voice u_voice (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .flush_i     (flush_i),
            .load_i      (load[gi]),
            .tick_i      (tick),
            .req_i       (req),
            .active_o    (active[gi]),
            .note_o      (voice_notes_o[gi*NOTE_W +: NOTE_W]),
            .meta_o      (voice_meta_o[gi*META_W +: META_W]),
            .remaining_o (remaining[gi]),
            .expiring_o  (expiring[gi])
        );
    end

    // Stealing only happens when every slot is active, so all remaining values are live
    always_comb begin
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (free[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        steal_idx = '0;
        steal_rem = remaining[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (remaining[i] < steal_rem) begin
                steal_rem = remaining[i];
                steal_idx = IDX_W'(i);
            end
        end
        sel_idx = free_hit ? free_idx : steal_idx;
        load    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            load[i] = req_valid && (sel_idx == IDX_W'(i));
        end
    end

    assign note_done_d = (|expiring) & ~flush_i;
    assign dropped_d   = new_note_i & ~flush_i & ~req_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            note_done_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            note_done_q <= note_done_d;
            dropped_q   <= dropped_d;
        end
    end

    assign voice_active_o = active;
    assign note_done_o    = note_done_q;
    assign dropped_o      = dropped_q;

endmodule

// File: tb/tb_note_voice_allocator.sv
// tb/tb_note_voice_allocator.sv - directed and randomized checks of note_voice_allocator against a slot-table model
module tb_note_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, play, beat, new_note;
    logic [5:0]    note, dur;
    logic [2:0]    meta;
    logic [NV-1:0]   voice_active;
    logic [6*NV-1:0] voice_notes;
    logic [3*NV-1:0] voice_meta;
    logic          note_done, dropped;

    int tests = 0;
    int fails = 0;

    int m_act [NV];
    int m_note[NV];
    int m_meta[NV];
    int m_rem [NV];
    int m_done, m_drop;

    always #5 clk = ~clk;

    note_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .play_i         (play),
        .beat_i         (beat),
        .new_note_i     (new_note),
        .note_i         (note),
        .duration_i     (dur),
        .metadata_i     (meta),
        .voice_active_o (voice_active),
        .voice_notes_o  (voice_notes),
        .voice_meta_o   (voice_meta),
        .note_done_o    (note_done),
        .dropped_o      (dropped)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_meta[i] = 0; m_rem[i] = 0;
        end
        m_done = 0;
        m_drop = 0;
    endtask

    // Slot table updated from the behavioural rules, one call per clock edge
    task automatic model_step();
        int tick;
        int any_exp;
        int slot;
        tick    = (play && beat) ? 1 : 0;
        any_exp = 0;
        m_done  = 0;
        m_drop  = 0;
        if (flush) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] != 0 && tick != 0 && m_rem[i] == 1) begin
                m_act[i] = 0; m_note[i] = 0; m_meta[i] = 0; m_rem[i] = 0;
                any_exp = 1;
            end else if (m_act[i] != 0 && tick != 0) begin
                m_rem[i] = m_rem[i] - 1;
            end
        end
        m_done = any_exp;
        if (new_note) begin
            if (note == 0 || dur == 0) begin
                m_drop = 1;
            end else begin
                slot = -1;
                for (int i = 0; i < NV; i++) if (slot < 0 && m_act[i] == 0) slot = i;
                if (slot < 0) begin
                    slot = 0;
                    for (int i = 1; i < NV; i++) if (m_rem[i] < m_rem[slot]) slot = i;
                end
                m_act[slot]  = 1;
                m_note[slot] = int'(note);
                m_meta[slot] = int'(meta);
                m_rem[slot]  = int'(dur);
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NV-1:0]   ea;
        logic [6*NV-1:0] en;
        logic [3*NV-1:0] em;
        for (int i = 0; i < NV; i++) begin
            ea[i]       = (m_act[i] != 0);
            en[6*i +: 6] = 6'(m_note[i]);
            em[3*i +: 3] = 3'(m_meta[i]);
        end
        chk({tag, "_active"}, 64'(voice_active), 64'(ea));
        chk({tag, "_notes"},  64'(voice_notes),  64'(en));
        chk({tag, "_meta"},   64'(voice_meta),   64'(em));
        chk({tag, "_done"},   64'(note_done),    64'(m_done));
        chk({tag, "_drop"},   64'(dropped),      64'(m_drop));
    endtask

    task automatic cyc(input string tag, input bit f, input bit b, input bit nn,
                       input int n, input int d, input int m);
        flush = f; beat = b; new_note = nn;
        note = 6'(n); dur = 6'(d); meta = 3'(m);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        flush = 1'b0; beat = 1'b0; new_note = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; play = 1'b0; beat = 1'b0; new_note = 1'b0;
        note = '0; dur = '0; meta = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_active", 64'(voice_active), 64'd0);
        chk("reset_notes",  64'(voice_notes),  64'd0);
        rst_n = 1'b1;

        // 1: async reset mid-play, then a single note expiring after three beats
        play = 1'b1;
        cyc("t1_pre", 0, 0, 1, 5, 9, 2);
        cyc("t1_beat", 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_async_active", 64'(voice_active), 64'd0);
        chk("t1_async_notes",  64'(voice_notes),  64'd0);
        chk("t1_async_meta",   64'(voice_meta),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("t1_load", 0, 0, 1, 12, 3, 1);
        chk("t1_slot0_note", 64'(voice_notes[5:0]), 64'd12);
        for (int k = 0; k < 3; k++) begin
            cyc("t1_beat", 0, 1, 0, 0, 0, 0);
            cyc("t1_idle", 0, 0, 0, 0, 0, 0);
        end
        chk("t1_expired", 64'(voice_active[0]), 64'd0);

        // 2: chord of three back-to-back notes expiring together
        cyc("t2_n0", 0, 0, 1, 20, 4, 3);
        cyc("t2_n1", 0, 0, 1, 24, 4, 4);
        cyc("t2_n2", 0, 0, 1, 27, 4, 5);
        chk("t2_three_active", 64'(voice_active), 64'h7);
        for (int k = 0; k < 4; k++) cyc("t2_beat", 0, 1, 0, 0, 0, 0);
        chk("t2_single_done", 64'(note_done), 64'd1);
        cyc("t2_after", 0, 0, 0, 0, 0, 0);

        // 3: steal the slot with the smallest remaining, lowest index on ties
        cyc("t3_flush", 1, 0, 0, 0, 0, 0);
        cyc("t3_a", 0, 0, 1, 1, 10, 0);
        cyc("t3_b", 0, 0, 1, 2, 5, 0);
        cyc("t3_c", 0, 0, 1, 3, 5, 0);
        cyc("t3_d", 0, 0, 1, 4, 8, 0);
        cyc("t3_steal", 0, 0, 1, 30, 2, 6);
        chk("t3_slot1_note", 64'(voice_notes[11:6]), 64'd30);
        for (int k = 0; k < 2; k++) cyc("t3_beat", 0, 1, 0, 0, 0, 0);
        chk("t3_slot1_gone", 64'(voice_active), 64'hd);

        // 4: pause freezes the countdown
        cyc("t4_flush", 1, 0, 0, 0, 0, 0);
        cyc("t4_load", 0, 0, 1, 9, 2, 1);
        cyc("t4_beat", 0, 1, 0, 0, 0, 0);
        play = 1'b0;
        for (int k = 0; k < 10; k++) cyc("t4_paused", 0, 1, 0, 0, 0, 0);
        chk("t4_still_active", 64'(voice_active[0]), 64'd1);
        play = 1'b1;
        cyc("t4_resume", 0, 1, 0, 0, 0, 0);
        chk("t4_expired", 64'(voice_active[0]), 64'd0);

        // 5: expiry and reload of the same slot on one edge
        cyc("t5_load", 0, 0, 1, 11, 1, 2);
        cyc("t5_swap", 0, 1, 1, 40, 6, 7);
        chk("t5_note40", 64'(voice_notes[5:0]), 64'd40);
        chk("t5_done",   64'(note_done), 64'd1);
        for (int k = 0; k < 6; k++) cyc("t5_beat", 0, 1, 0, 0, 0, 0);

        // 6: invalid notes drop, flush swallows a concurrent note
        cyc("t6_load", 0, 0, 1, 15, 20, 3);
        cyc("t6_zero_note", 0, 0, 1, 0, 5, 1);
        chk("t6_dropped", 64'(dropped), 64'd1);
        cyc("t6_zero_dur", 0, 0, 1, 7, 0, 1);
        cyc("t6_flush", 1, 1, 1, 22, 5, 2);
        chk("t6_flush_clear", 64'(voice_active), 64'd0);
        chk("t6_flush_nodrop", 64'(dropped), 64'd0);

        // Randomized traffic including chords, steals, pauses and flushes
        for (int k = 0; k < 3000; k++) begin
            int n, d;
            play = ($urandom_range(0, 9) != 0);
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
            d = ($urandom_range(0, 9) == 0) ? 0 :
                ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(1, 8));
            cyc("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), n, d, int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
